multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 170 +++++++++++++++++
 tb/tb_multicycle_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: FORWARD/ADD/AND/OR/SUB in one cycle, optional shift-add MUL over WIDTH cycles.
// Latency: 1 cycle after acceptance for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: one operation in flight; IN_READY only in IDLE, result held in DONE until OUT_READY.
// Optional feature macro: MULTICYCLE_ALU_MUL_EN enables the multiplier (SELECT=101); otherwise 101 is reserved.
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             ZERO,
    output logic             ILLEGAL,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             illegal_q;

    logic             accept;
    logic             start_mul;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_illegal;

`ifdef MULTICYCLE_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // prod_q holds {partial high half, remaining multiplier bits}
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     hi_sum;
    logic               mul_last;

    // One shift-add step: add multiplicand to the high half if the current multiplier bit is set, then shift right
    always_comb begin
        hi_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {hi_sum, prod_q[WIDTH-1:1]};
    end

    assign start_mul = (SELECT == 3'b101);
    assign mul_last  = (cnt_q == CNT_LAST);
`else
    assign start_mul = 1'b0;
`endif

    assign accept  = IN_VALID & IN_READY;
    assign sum_ext = {1'b0, DATA1} + {1'b0, DATA2};

    // Single-cycle operation results, computed from the live inputs and captured on acceptance
    always_comb begin
        alu_res     = DATA2;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        case (SELECT)
            3'b000: alu_res = DATA2;
            3'b001: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            3'b010: alu_res = DATA1 & DATA2;
            3'b011: alu_res = DATA1 | DATA2;
            3'b100: begin
                alu_res   = DATA1 - DATA2;
                alu_carry = (DATA1 >= DATA2);
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            3'b101: alu_res = DATA2;
`endif
            default: begin
                alu_res     = DATA2;
                alu_illegal = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a DONE->IDLE edge never accepts a request because IN_READY is low in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = start_mul ? S_BUSY : S_DONE;
`ifdef MULTICYCLE_ALU_MUL_EN
            S_BUSY: if (mul_last) state_d = S_DONE;
`endif
            S_DONE: if (OUT_READY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        IN_READY  = (state_q == S_IDLE) & ~RESET;
        OUT_VALID = (state_q == S_DONE);
    end

    // Result/flag registers: written on single-cycle acceptance or on the last multiply step, otherwise held
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && accept && !start_mul) begin
                result_q  <= alu_res;
                carry_q   <= alu_carry;
                zero_q    <= (alu_res == '0);
                illegal_q <= alu_illegal;
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            else if (state_q == S_BUSY && mul_last) begin
                result_q  <= prod_step[WIDTH-1:0];
                carry_q   <= |prod_step[2*WIDTH-1:WIDTH];
                zero_q    <= (prod_step[WIDTH-1:0] == '0);
                illegal_q <= 1'b0;
            end
`endif
        end
    end

`ifdef MULTICYCLE_ALU_MUL_EN
    // Multiplier accumulator and step counter; loaded on MUL acceptance, stepped once per BUSY cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (state_q == S_IDLE && accept && start_mul) begin
            prod_q  <= {{WIDTH{1'b0}}, DATA1};
            mcand_q <= DATA2;
            cnt_q   <= '0;
        end else if (state_q == S_BUSY) begin
            prod_q  <= prod_step;
            cnt_q   <= cnt_q + CW'(1);
        end
    end
`endif

    assign RESULT  = result_q;
    assign CARRY   = carry_q;
    assign ZERO    = zero_q;
    assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=8), adapting to MULTICYCLE_ALU_MUL_EN.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants.
module tb_multicycle_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d1, d2;
    logic [2:0] sel;
    logic       in_vld, in_rdy;
    logic [7:0] res;
    logic       carry, zero, illegal, out_vld, out_rdy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_R6  = 3'b110;

    multicycle_alu #(.WIDTH(8)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .DATA1     (d1),
        .DATA2     (d2),
        .SELECT    (sel),
        .IN_VALID  (in_vld),
        .IN_READY  (in_rdy),
        .RESULT    (res),
        .CARRY     (carry),
        .ZERO      (zero),
        .ILLEGAL   (illegal),
        .OUT_VALID (out_vld),
        .OUT_READY (out_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request, let it be accepted, then scramble the operand inputs
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        sel    = op;
        d1     = a;
        d2     = b;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        d1     = 8'($urandom);
        d2     = 8'($urandom);
        sel    = 3'($urandom_range(0, 7));
    endtask

    task automatic check_out(input string tag, input logic [7:0] r, input logic c, input logic z, input logic il);
        chk({tag, "_vld"},  out_vld, 1);
        chk({tag, "_res"},  res,     r);
        chk({tag, "_cy"},   carry,   c);
        chk({tag, "_zero"}, zero,    z);
        chk({tag, "_ill"},  illegal, il);
        chk({tag, "_nrdy"}, in_rdy,  0);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        chk({tag, "_drop"}, out_vld, 0);
        chk({tag, "_idle"}, in_rdy,  1);
    endtask

    initial begin
        int vld_seen;
        rst     = 1'b1;
        d1      = '0;
        d2      = '0;
        sel     = '0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;

        // Reset values, before any clock edge
        #2;
        chk("rst_res",  res,     0);
        chk("rst_cy",   carry,   0);
        chk("rst_zero", zero,    0);
        chk("rst_ill",  illegal, 0);
        chk("rst_vld",  out_vld, 0);
        chk("rst_rdy",  in_rdy,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy", in_rdy, 1);

        // ADD 200+100 = 300 -> 44 with carry, valid one cycle after accept
        issue(OP_ADD, 8'd200, 8'd100);
        check_out("add", 8'd44, 1'b1, 1'b0, 1'b0);
        release_out("add");

        issue(OP_SUB, 8'd5, 8'd5);
        check_out("sub_eq", 8'd0, 1'b1, 1'b1, 1'b0);
        release_out("sub_eq");

        issue(OP_SUB, 8'd3, 8'd5);
        check_out("sub_brw", 8'd254, 1'b0, 1'b0, 1'b0);
        release_out("sub_brw");

        issue(OP_FWD, 8'h33, 8'h5A);
        check_out("fwd", 8'h5A, 1'b0, 1'b0, 1'b0);
        release_out("fwd");

        // OR held for 3 cycles while a new request is presented and must be ignored
        issue(OP_OR, 8'h0F, 8'hF0);
        check_out("or", 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sel    = OP_ADD;
            d1     = 8'd1;
            d2     = 8'd1;
            in_vld = 1'b1;
            @(posedge clk);
            #1;
            chk("or_hold_res", res,     8'hFF);
            chk("or_hold_vld", out_vld, 1);
            chk("or_hold_rdy", in_rdy,  0);
        end
        // Release with IN_VALID still high: no accept on the release edge
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        chk("or_rel_vld", out_vld, 0);
        chk("or_rel_rdy", in_rdy,  1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        check_out("add_next", 8'd2, 1'b0, 1'b0, 1'b0);
        release_out("add_next");

`ifdef MULTICYCLE_ALU_MUL_EN
        // MUL 12*11 = 132: RESULT holds prior value (2) during BUSY, valid after 9 cycles
        issue(OP_MUL, 8'd12, 8'd11);
        chk("mul_busy_vld", out_vld, 0);
        chk("mul_busy_res", res,     8'd2);
        chk("mul_busy_rdy", in_rdy,  0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("mul_busy_vld", out_vld, 0);
            chk("mul_busy_res", res,     8'd2);
        end
        @(posedge clk);
        #1;
        check_out("mul", 8'd132, 1'b0, 1'b0, 1'b0);
        release_out("mul");

        issue(OP_MUL, 8'd16, 8'd16);
        repeat (8) @(posedge clk);
        #1;
        check_out("mul_ovf", 8'd0, 1'b1, 1'b1, 1'b0);
        release_out("mul_ovf");
`else
        // Multiplier absent: 101 is reserved, latency 1
        issue(OP_MUL, 8'd12, 8'd7);
        check_out("r5", 8'd7, 1'b0, 1'b0, 1'b1);
        release_out("r5");
`endif

        issue(OP_R6, 8'd9, 8'd0);
        check_out("r6", 8'd0, 1'b0, 1'b1, 1'b1);
        release_out("r6");

        // Reset in the middle of an operation aborts it
`ifdef MULTICYCLE_ALU_MUL_EN
        issue(OP_MUL, 8'd12, 8'd11);
`else
        issue(OP_ADD, 8'd200, 8'd100);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_vld", out_vld, 0);
        chk("abort_res", res,     0);
        chk("abort_ill", illegal, 0);
        chk("abort_rdy", in_rdy,  0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_rel_rdy", in_rdy, 1);
        vld_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_vld === 1'b1) vld_seen++;
        end
        chk("abort_no_vld", vld_seen, 0);

        issue(OP_AND, 8'hAA, 8'h0F);
        check_out("and", 8'h0A, 1'b0, 1'b0, 1'b0);
        release_out("and");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
